// File: rtl/pwl_delay_line.sv
// pwl_delay_line
//
// Multi-channel PWL transport delay. Every input segment on a channel is
// queued in a small per-channel FIFO together with its release time, and is
// re-emitted, scaled by SCALE, exactly dly_cur seconds after it arrived. The
// t0 of the released segment is shifted by the same delay, so the output
// waveform is a time-shifted, scaled copy of the input.
//
// A PWL value is carried as three reals (a, b, t0). The waveform is
// a + b*(t - t0), with times in seconds. Each channel also has an event
// toggle bit. Flipping it marks a new input segment, so a re-sent segment
// with the same value is still seen as an event.
//
// Optional feature macro: PWL_DELAY_LINE_DROP_OLDEST_EN
//   defined   : on overflow the oldest queued segment is discarded and the
//               new one is accepted.
//   undefined : on overflow the new segment is discarded.
//   ovf is set the same way in both builds.
//
// Ports
//   clk       sampling clock for the delay register and status
//   rstn      asynchronous active-low reset
//   dly_in    requested delay in seconds; negative values load as 0.0
//   dly_ld    load request for dly_in, sampled on rising clk
//   in_a      per-channel input segment offset a
//   in_b      per-channel input segment slope b (units per second)
//   in_t0     per-channel input segment reference time t0 (seconds)
//   in_ev     per-channel event toggle; any change marks a new segment
//   out_a     per-channel delayed, scaled offset
//   out_b     per-channel delayed, scaled slope
//   out_t0    per-channel delayed reference time
//   dly_cur   delay currently applied to new segments
//   dly_busy  a delay load is parked until every FIFO has drained
//   ovf       sticky per-channel overflow flag
//
// The delay register is clocked logic. The segment path is an event-driven
// behavioural model, because release times are real-valued and are not
// quantised to the clock.

`timescale 1ns/1ps

module pwl_delay_line #(
  parameter int  NCH        = 1,
  parameter int  DEPTH      = 8,
  parameter real SCALE      = 1.0,
  parameter real DELAY_INIT = 0.0
) (
  input  logic           clk,
  input  logic           rstn,
  input  real            dly_in,
  input  logic           dly_ld,
  input  real            in_a  [NCH],
  input  real            in_b  [NCH],
  input  real            in_t0 [NCH],
  input  logic [NCH-1:0] in_ev,
  output real            out_a  [NCH],
  output real            out_b  [NCH],
  output real            out_t0 [NCH],
  output real            dly_cur,
  output logic           dly_busy,
  output logic [NCH-1:0] ovf
);

  // Simulator time units are nanoseconds. All interface times are seconds.
  localparam real SEC_PER_TU = 1.0e-9;
  localparam real TU_PER_SEC = 1.0e9;
  // A release is due once simulated time is within half a picosecond of it.
  // This absorbs rounding of delays to the 1 ps time precision.
  localparam real T_EPS      = 0.5e-12;

  function automatic real now_s();
    return $realtime * SEC_PER_TU;
  endfunction

  // ---------------------------------------------------------------------------
  // Delay register state machine
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t         state;
  state_t         state_nx;
  real            dly_cur_r;
  real            dly_cur_nx;
  real            pend_r;
  real            pend_nx;
  real            dly_req;
  logic [NCH-1:0] chan_empty;
  logic           all_empty;

  assign all_empty = &chan_empty;
  assign dly_req   = (dly_in < 0.0) ? 0.0 : dly_in;
  assign dly_cur   = dly_cur_r;
  assign dly_busy  = (state == S_WAIT);

  // Next-state logic.
  // A load applies at once only when nothing is queued, so queued segments
  // always keep the delay they were pushed with. Otherwise the request is
  // parked until the last FIFO drains. A newer request replaces the parked
  // one, including a request on the same edge that applies it.
  always_comb begin
    state_nx   = state;
    dly_cur_nx = dly_cur_r;
    pend_nx    = pend_r;
    case (state)
      S_IDLE: begin
        if (dly_ld) begin
          if (all_empty) begin
            dly_cur_nx = dly_req;
          end else begin
            pend_nx  = dly_req;
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dly_ld) begin
          pend_nx = dly_req;
        end
        if (all_empty) begin
          dly_cur_nx = dly_ld ? dly_req : pend_r;
          state_nx   = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and delay registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      dly_cur_r <= DELAY_INIT;
      pend_r    <= DELAY_INIT;
    end else begin
      state     <= state_nx;
      dly_cur_r <= dly_cur_nx;
      pend_r    <= pend_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel segment FIFOs and release scheduling
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    real  q_a   [DEPTH];
    real  q_b   [DEPTH];
    real  q_t0  [DEPTH];  // t0 already shifted by the delay at push time
    real  q_rel [DEPTH];  // absolute release time, seconds
    int   rd;
    int   wr;
    int   cnt;
    logic last_ev;
    logic ovf_r;
    real  oa;
    real  ob;
    real  ot0;

    assign out_a[gi]      = oa;
    assign out_b[gi]      = ob;
    assign out_t0[gi]     = ot0;
    assign ovf[gi]        = ovf_r;
    assign chan_empty[gi] = (cnt == 0);

    // One process owns all of this channel's state. Each pass handles one
    // of these, in priority order:
    //   1. reset
    //   2. a pending input event (push)
    //   3. a due release (pop)
    //   4. sleep until the next release time, input event or reset.
    // Handling the push before the pop lets a zero-delay segment release in
    // the same timestep, after its push. Because pushes run in arrival
    // order, the last event of a timestep is the one left on the output.
    // Blocking assignments are used on purpose: the ordering inside a
    // timestep is part of the behaviour.
    always begin : chan_proc
      if (!rstn) begin
        rd    = 0;
        wr    = 0;
        cnt   = 0;
        ovf_r = 1'b0;
        oa    = 0.0;
        ob    = 0.0;
        ot0   = now_s();
        @(posedge rstn);
        // Events seen while in reset are ignored.
        last_ev = in_ev[gi];
      end else if (in_ev[gi] != last_ev) begin
        last_ev = in_ev[gi];
        if (now_s() == 0.0) begin
          // Initial value at time zero passes straight through.
          oa  = SCALE * in_a[gi];
          ob  = SCALE * in_b[gi];
          ot0 = in_t0[gi];
        end else begin
          if (cnt == DEPTH) begin
            ovf_r = 1'b1;
`ifdef PWL_DELAY_LINE_DROP_OLDEST_EN
            // Make room by giving up the oldest unreleased segment.
            rd  = (rd == DEPTH - 1) ? 0 : rd + 1;
            cnt = cnt - 1;
`endif
          end
          if (cnt < DEPTH) begin
            q_a[wr]   = in_a[gi];
            q_b[wr]   = in_b[gi];
            q_t0[wr]  = in_t0[gi] + dly_cur_r;
            q_rel[wr] = now_s() + dly_cur_r;
            wr        = (wr == DEPTH - 1) ? 0 : wr + 1;
            cnt       = cnt + 1;
          end
        end
      end else if ((cnt != 0) && (q_rel[rd] <= now_s() + T_EPS)) begin
        oa  = SCALE * q_a[rd];
        ob  = SCALE * q_b[rd];
        ot0 = q_t0[rd];
        rd  = (rd == DEPTH - 1) ? 0 : rd + 1;
        cnt = cnt - 1;
      end else if (cnt != 0) begin
        // Release times never decrease within a channel, so only the head
        // needs a timer. Branches that are left waiting after the join do
        // nothing when they finish.
        fork
          #((q_rel[rd] - now_s()) * TU_PER_SEC);
          @(in_ev[gi]);
          @(negedge rstn);
        join_any
      end else begin
        fork
          @(in_ev[gi]);
          @(negedge rstn);
        join_any
      end
    end
  end

endmodule

// File: doc/pwl_delay_line.md
# pwl_delay_line

Multi-channel PWL transport delay with a clocked delay register and bounded per-channel segment buffering. Each channel stores incoming PWL segments in a fixed-depth FIFO and re-emits them, scaled, exactly `delay` seconds later with `t0` shifted by the same amount, so the output waveform is a time-shifted copy of the input. Delay updates are clock-synchronous and applied only when no segments are in flight, so segments are never reordered or dropped by a delay change. It sits in mLingua primitive-level channel and timing models wherever a variable, controllable delay on PWL nets is needed.

## Interface
- NCH, 1: number of independent PWL channels sharing one delay register.
- DEPTH, 8: per-channel FIFO depth in segments, at least 2.
- SCALE, 1.0: real gain applied to both `a` and `b` of every output segment.
- DELAY_INIT, 0.0: delay register value in seconds after reset.
- clk  input  1  sampling clock for delay load and status.
- rstn  input  1  reset, asynchronous, active-low.
- dly_in  input  real  requested delay in seconds, 0 or greater.
- dly_ld  input  1  load request for `dly_in`, sampled on rising `clk`.
- in  input  pwl[NCH]  PWL inputs.
- out  output  pwl[NCH]  delayed, scaled PWL outputs.
- dly_cur  output  real  delay currently in effect.
- dly_busy  output  1  a load is pending and waits for the buffers to drain.
- ovf  output  NCH  sticky per-channel overflow flag.

## Operation
- Reset, `rstn`=0: all FIFOs flushed and scheduled releases cancelled. `out[i]` = (a=0, b=0, t0=$realtime). `dly_cur`=DELAY_INIT, `dly_busy`=0, `ovf`=0, state IDLE.
- Input event on `in[i]` at time t, with `rstn`=1:
  - At t=0, `out[i]` takes `in[i]` directly with scaling and no buffering.
  - Otherwise push {a, b, t0, t_rel=t+dly_cur} into FIFO i.
- Release: when `$realtime` reaches the head's `t_rel`, pop the head and drive `out[i]` = pm.write(SCALE·a, SCALE·b, t0+dly_cur_at_push).
  - t_rel is non-decreasing within a channel, so FIFO order is release order.
  - Zero-delay entries release in the same timestep, after the push.
  - Two input events at the same timestep produce two pushes; on release the last value wins.
- Overflow: a push to a full FIFO sets `ovf[i]`, which is sticky until reset. Which entry is discarded is set by the macro under Configuration.
- Delay state machine, evaluated on rising `clk`:
  - IDLE: `dly_ld`=1 and all FIFOs empty: `dly_cur`←`dly_in` and stay IDLE. `dly_ld`=1 and any FIFO non-empty: latch `dly_in` into a pending register and go to WAIT with `dly_busy`=1.
  - WAIT: all FIFOs empty at the edge: `dly_cur`←pending, `dly_busy`=0, go to IDLE. `dly_ld`=1 in WAIT overwrites the pending value; the last request wins.
  - While in WAIT, new pushes still use the old `dly_cur`.
- Negative `dly_in` is clamped to 0.0 when loaded.

## Timing
- The output segment for an input event at time t appears at exactly t+delay. No clock quantisation applies to data.
- A delay load takes effect on the same rising `clk` edge in IDLE. In WAIT it takes effect on the first rising edge after the last FIFO empties.
- `dly_busy` rises on the load edge that enters WAIT and falls on the applying edge.
- Assertion of `rstn` mid-flight cancels pending releases immediately, with no clock needed. Deassertion resumes operation at the next input event or clock edge.
- `ovf` sets in the same timestep as the rejected push.

## Configuration
- PWL_DELAY_LINE_DROP_OLDEST_EN:
  - Defined: on overflow, discard the head (oldest unreleased) entry and accept the new one, keeping the most recent waveform.
  - Undefined: discard the new entry and keep the FIFO unchanged.
  - `ovf` behaviour is identical in both cases.

## Test plan
- Reset `dly_cur`=1ns, step `in[0]` to a=0.5, b=0 at 10ns -> `out[0]` stays 0 until 11ns, then a=0.5·SCALE with t0=11ns.
- Ramp a=0, b=1e9 at 20ns with delay 2ns -> `out` value at 25ns equals input value at 23ns, within 1e-12.
- Load 3ns while two segments are in flight -> `dly_busy`=1. Segments release with the old delay. `dly_cur`=3ns on the first clk edge after drain, then `dly_busy`=0.
- DEPTH=2, three events within a 5ns delay window -> `ovf[0]`=1. With the macro defined, output shows events 2 and 3; without it, events 1 and 2.
- Pull `rstn` low with 3 entries pending -> `out`=0 immediately and no later releases. After `rstn`=1, `dly_cur`=DELAY_INIT and `ovf`=0.
- NCH=4 with distinct events per channel and the same delay -> each channel is independent; an overflow on channel 2 sets only `ovf[2]`.
